// File: rtl/nco_efm_dac.sv
`default_nettype none
// ============================================================================
//  Module      : nco_efm_dac
//  Description : Phase-accumulator NCO with an elaboration-time sine ROM,
//                feeding a first-order error-feedback delta-sigma modulator
//                that emits a 1-bit pulse-density stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module nco_efm_dac #(
  parameter int WIDTH          = 16,
  parameter int LUT_DEPTH      = 256,
  parameter int ACC_FRAC_WIDTH = 24,
  parameter int ACC_INT_WIDTH  = $clog2(LUT_DEPTH),
  parameter int ACC_WIDTH      = ACC_INT_WIDTH + ACC_FRAC_WIDTH
) (
  input  logic                     aclk,
  input  logic                     arst,
  input  logic [ACC_INT_WIDTH-1:0] phase_shift,
  input  logic [ACC_WIDTH-1:0]     s_axis_step_tdata,
  input  logic                     s_axis_step_tvalid,
  output logic                     s_axis_step_tready,
  output logic [WIDTH-1:0]         m_axis_sample_tdata,
  output logic                     m_axis_sample_tvalid,
  output logic                     m_axis_dsm_tdata,
  output logic                     m_axis_dsm_tvalid
);

  localparam int  c_mid = 2 ** (WIDTH - 1);
  localparam int  c_amp = 2 ** (WIDTH - 1) - 1;
  localparam real c_pi  = 3.14159265358979323846;

  // Offset-binary sine entry, rounded half away from zero.
  function automatic logic [WIDTH-1:0] lut_entry(input int k);
    real r;
    int  val;
    r = real'(c_amp) * $sin(2.0 * c_pi * real'(k) / real'(LUT_DEPTH));
    if (r >= 0.0) val = c_mid + $rtoi(r + 0.5);
    else          val = c_mid - $rtoi(0.5 - r);
    return val[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] lut_rom [LUT_DEPTH];

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
    localparam logic [WIDTH-1:0] c_lut_val = lut_entry(k);
    assign lut_rom[k] = c_lut_val;
  end

  logic                     ready_q,        ready_d;
  logic                     run_q,          run_d;
  logic [ACC_WIDTH-1:0]     step_q,         step_d;
  logic [ACC_WIDTH-1:0]     acc_q,          acc_d;
  logic [WIDTH-1:0]         sample_q,       sample_d;
  logic                     sample_valid_q, sample_valid_d;
  logic [WIDTH-1:0]         err_q,          err_d;
  logic                     dsm_q,          dsm_d;
  logic                     dsm_valid_q,    dsm_valid_d;

  logic [ACC_INT_WIDTH-1:0] w_addr;
  logic [WIDTH:0]           w_sum;

  // Next-state: step capture, phase accumulation, ROM read and EFM update.
  always_comb begin
    ready_d        = 1'b1;
    run_d          = run_q;
    step_d         = step_q;
    acc_d          = acc_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    err_d          = err_q;
    dsm_d          = dsm_q;
    dsm_valid_d    = 1'b0;

    // Address uses the accumulator value before this cycle's update.
    w_addr = acc_q[ACC_WIDTH-1 -: ACC_INT_WIDTH] + phase_shift;
    w_sum  = {1'b0, sample_q} + {1'b0, err_q};

    // A new step replaces the old one without touching acc (phase-continuous).
    if (s_axis_step_tvalid && ready_q) begin
      step_d = s_axis_step_tdata;
      run_d  = 1'b1;
    end

    if (run_q) begin
      acc_d          = acc_q + step_q;
      sample_d       = lut_rom[w_addr];
      sample_valid_d = 1'b1;
    end

    // Carry out of sample+err is the density bit; the remainder is fed back.
    if (sample_valid_q) begin
      dsm_d       = w_sum[WIDTH];
      err_d       = w_sum[WIDTH-1:0];
      dsm_valid_d = 1'b1;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge aclk) begin
    if (arst) begin
      ready_q        <= 1'b0;
      run_q          <= 1'b0;
      step_q         <= '0;
      acc_q          <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      err_q          <= '0;
      dsm_q          <= 1'b0;
      dsm_valid_q    <= 1'b0;
    end else begin
      ready_q        <= ready_d;
      run_q          <= run_d;
      step_q         <= step_d;
      acc_q          <= acc_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      err_q          <= err_d;
      dsm_q          <= dsm_d;
      dsm_valid_q    <= dsm_valid_d;
    end
  end

  assign s_axis_step_tready   = ready_q;
  assign m_axis_sample_tdata  = sample_q;
  assign m_axis_sample_tvalid = sample_valid_q;
  assign m_axis_dsm_tdata     = dsm_q;
  assign m_axis_dsm_tvalid    = dsm_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_nco_efm_dac.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nco_efm_dac
//  Description : Directed self-checking bench for nco_efm_dac.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nco_efm_dac;

  logic        aclk = 1'b0;
  logic        arst;
  logic [7:0]  phase_shift;
  logic [31:0] s_axis_step_tdata;
  logic        s_axis_step_tvalid;
  logic        s_axis_step_tready;
  logic [15:0] m_axis_sample_tdata;
  logic        m_axis_sample_tvalid;
  logic        m_axis_dsm_tdata;
  logic        m_axis_dsm_tvalid;

  int checks = 0;
  int errors = 0;

  nco_efm_dac dut (
    .aclk                 (aclk),
    .arst                 (arst),
    .phase_shift          (phase_shift),
    .s_axis_step_tdata    (s_axis_step_tdata),
    .s_axis_step_tvalid   (s_axis_step_tvalid),
    .s_axis_step_tready   (s_axis_step_tready),
    .m_axis_sample_tdata  (m_axis_sample_tdata),
    .m_axis_sample_tvalid (m_axis_sample_tvalid),
    .m_axis_dsm_tdata     (m_axis_dsm_tdata),
    .m_axis_dsm_tvalid    (m_axis_dsm_tvalid)
  );

  // 100 MHz clock
  always #5 aclk = ~aclk;

  // Reference sine table straight from the defining formula.
  function automatic int lut_model(input int k);
    real r;
    r = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(k % 256) / 256.0);
    if (r >= 0.0) return 32768 + $rtoi(r + 0.5);
    else          return 32768 - $rtoi(0.5 - r);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Two reset edges, then one edge so tready is up before a step is offered.
  task automatic do_reset();
    arst = 1'b1;
    tick();
    tick();
    arst = 1'b0;
    tick();
  endtask

  // Offer a step for one edge (E0); returns just after E0.
  task automatic start(input logic [31:0] step, input logic [7:0] ps);
    s_axis_step_tdata  = step;
    s_axis_step_tvalid = 1'b1;
    phase_shift        = ps;
    tick();
    s_axis_step_tvalid = 1'b0;
  endtask

  initial begin
    int m_err;
    int prev;
    int sum;
    int expv;
    longint idx;

    // ---------------- reset with tvalid held high ----------------
    arst               = 1'b1;
    phase_shift        = 8'd0;
    s_axis_step_tdata  = 32'd0;
    s_axis_step_tvalid = 1'b1;
    repeat (5) tick();
    check("rst_tready",       {31'd0, s_axis_step_tready},   32'd0);
    check("rst_sample",       {16'd0, m_axis_sample_tdata},  32'd0);
    check("rst_sample_valid", {31'd0, m_axis_sample_tvalid}, 32'd0);
    check("rst_dsm",          {31'd0, m_axis_dsm_tdata},     32'd0);
    check("rst_dsm_valid",    {31'd0, m_axis_dsm_tvalid},    32'd0);

    // Release: tready rises on the first edge, step accepted on the next.
    arst = 1'b0;
    tick();
    check("rel_tready",       {31'd0, s_axis_step_tready},   32'd1);
    check("rel_sample_valid", {31'd0, m_axis_sample_tvalid}, 32'd0);
    tick();  // E0: step = 0 accepted
    s_axis_step_tvalid = 1'b0;
    check("e0_sample_valid",  {31'd0, m_axis_sample_tvalid}, 32'd0);
    tick();  // E1
    check("e1_sample_valid",  {31'd0, m_axis_sample_tvalid}, 32'd1);
    check("e1_dsm_valid",     {31'd0, m_axis_dsm_tvalid},    32'd0);

    // ---------------- DC midscale: bits 0,1,0,1,... ----------------
    for (int i = 0; i < 8; i++) begin
      check("mid_sample", {16'd0, m_axis_sample_tdata}, 32'd32768);
      tick();
      check("mid_dsm_valid", {31'd0, m_axis_dsm_tvalid}, 32'd1);
      check("mid_dsm", {31'd0, m_axis_dsm_tdata}, (i % 2 == 0) ? 32'd0 : 32'd1);
    end

    // ---------------- LUT walk, step = 2^24 ----------------
    do_reset();
    start(32'h0100_0000, 8'd0);
    m_err = 0;
    prev  = 0;
    for (int k = 0; k <= 256; k++) begin
      tick();
      expv = lut_model(k);
      check("walk_sample", {16'd0, m_axis_sample_tdata}, expv);
      if (k == 1)   check("walk_lut1",   {16'd0, m_axis_sample_tdata}, 32'd33572);
      if (k == 16)  check("walk_lut16",  {16'd0, m_axis_sample_tdata}, 32'd45307);
      if (k == 32)  check("walk_lut32",  {16'd0, m_axis_sample_tdata}, 32'd55938);
      if (k == 64)  check("walk_lut64",  {16'd0, m_axis_sample_tdata}, 32'd65535);
      if (k == 128) check("walk_lut128", {16'd0, m_axis_sample_tdata}, 32'd32768);
      if (k == 192) check("walk_lut192", {16'd0, m_axis_sample_tdata}, 32'd1);
      if (k == 224) check("walk_lut224", {16'd0, m_axis_sample_tdata}, 32'd9598);
      if (k == 255) check("walk_lut255", {16'd0, m_axis_sample_tdata}, 32'd31964);
      if (k == 256) check("walk_wrap",   {16'd0, m_axis_sample_tdata}, 32'd32768);
      if (k > 0) begin
        sum   = prev + m_err;
        m_err = sum % 65536;
        check("walk_dsm", {31'd0, m_axis_dsm_tdata}, (sum >= 65536) ? 32'd1 : 32'd0);
      end
      prev = expv;
    end

    // ---------------- reload to 2^25: no phase jump ----------------
    s_axis_step_tdata  = 32'h0200_0000;
    s_axis_step_tvalid = 1'b1;
    tick();
    s_axis_step_tvalid = 1'b0;
    check("reload_s0", {16'd0, m_axis_sample_tdata}, lut_model(1));
    tick();
    check("reload_s1", {16'd0, m_axis_sample_tdata}, lut_model(2));
    tick();
    check("reload_s2", {16'd0, m_axis_sample_tdata}, lut_model(4));
    tick();
    check("reload_s3", {16'd0, m_axis_sample_tdata}, lut_model(6));

    // ---------------- reset mid-run ----------------
    arst = 1'b1;
    tick();
    check("mid_rst_tready",       {31'd0, s_axis_step_tready},   32'd0);
    check("mid_rst_sample",       {16'd0, m_axis_sample_tdata},  32'd0);
    check("mid_rst_sample_valid", {31'd0, m_axis_sample_tvalid}, 32'd0);
    check("mid_rst_dsm",          {31'd0, m_axis_dsm_tdata},     32'd0);
    check("mid_rst_dsm_valid",    {31'd0, m_axis_dsm_tvalid},    32'd0);
    arst = 1'b0;
    tick();

    // ---------------- DC peak after reset, phase_shift = 64 ----------------
    start(32'd0, 8'd64);
    tick();
    check("peak_first_sample", {16'd0, m_axis_sample_tdata}, 32'd65535);
    tick();
    check("peak_first_bit", {31'd0, m_axis_dsm_tdata}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      tick();
      check("peak_ones", {31'd0, m_axis_dsm_tdata}, 32'd1);
    end

    // ---------------- phase_shift applied from the start ----------------
    do_reset();
    start(32'h0100_0000, 8'd200);
    tick();
    check("ps200_s0", {16'd0, m_axis_sample_tdata}, lut_model(200));
    tick();
    check("ps200_s1", {16'd0, m_axis_sample_tdata}, lut_model(201));

    // ---------------- audio-rate step, fractional accumulation ----------------
    do_reset();
    start(32'd85900, 8'd0);
    for (int k = 0; k < 2000; k++) begin
      tick();
      idx = (longint'(k) * 64'd85900) >> 24;
      check("tone_sample", {16'd0, m_axis_sample_tdata}, lut_model(int'(idx % 256)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
